// File: rtl/seg7_pkg.sv
// Shared types and segment glyph constants for the 7-segment scan driver.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [6:0] SEG_BLANK = 7'b000_0000;
  localparam logic [6:0] SEG_DASH  = 7'b100_0000;

  // Element [n] is the glyph for decimal digit n.
  localparam logic [9:0][6:0] SEG_GLYPHS = {
    7'b110_1111,  // 9
    7'b111_1111,  // 8
    7'b000_0111,  // 7
    7'b111_1101,  // 6
    7'b110_1101,  // 5
    7'b110_0110,  // 4
    7'b100_1111,  // 3
    7'b101_1011,  // 2
    7'b000_0110,  // 1
    7'b011_1111   // 0
  };

endpackage

// File: rtl/bcd_2_seg7.sv
// Combinational BCD-to-7-segment decoder, active-high outputs.
// Codes 10-15 are not decimal and decode to a '-' glyph.
module bcd_2_seg7
  import seg7_pkg::*;
(
  input  bcd_digit_t  digit,
  output logic [6:0]  seg
);

  // Glyph lookup with dash fallback for non-decimal codes
  always_comb begin
    seg = SEG_DASH;
    if (digit <= 4'd9) begin
      seg = SEG_GLYPHS[digit];
    end else begin
      seg = SEG_DASH;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: frame-synchronous BCD commit, leading-zero
// blanking, anti-ghosting dead time and configurable pin polarity.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 3,
  parameter int REFRESH_DIV    = 50000,
  parameter int DEAD_CYCLES    = 500,
  parameter int BLANK_LEADING  = 1,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int ACTIVE_LOW_AN  = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [DIGITS-1:0][3:0] bcd_i,
  input  logic                   load_i,
  input  logic                   blank_i,
  input  logic [DIGITS-1:0]      dp_i,
  output logic [6:0]             seg_o,
  output logic                   dp_o,
  output logic [DIGITS-1:0]      an_o
);

  localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [TW-1:0]     TICK_LAST = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0]     TICK_DEAD = TW'(DEAD_CYCLES);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF   = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_OFF    = (ACTIVE_LOW_SEG != 0) ? 1'b1 : 1'b0;
  localparam logic [DIGITS-1:0] AN_OFF    = (ACTIVE_LOW_AN != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [TW-1:0]            tick_r, tick_nxt_s;
  logic [IW-1:0]            idx_r, idx_nxt_s;
  logic [DIGITS-1:0][3:0]   shadow_r, shadow_nxt_s;
  logic [DIGITS-1:0][3:0]   disp_r, disp_nxt_s;
  logic                     pending_r, pending_nxt_s;
  logic                     wrap_s, frame_s, active_s;
  logic [DIGITS-1:0]        lzb_s, an_nxt_s;
  logic [6:0]               glyph_s, seg_nxt_s;
  logic                     dp_nxt_s;
  bcd_digit_t               digit_s;

  // Scan counters and the shadow/display double buffer
  always_comb begin
    wrap_s        = (tick_r == TICK_LAST);
    frame_s       = wrap_s && (idx_r == IDX_LAST);
    tick_nxt_s    = wrap_s ? {TW{1'b0}} : tick_r + TW'(1);
    idx_nxt_s     = idx_r;
    shadow_nxt_s  = shadow_r;
    disp_nxt_s    = disp_r;
    pending_nxt_s = pending_r;
    if (wrap_s) begin
      idx_nxt_s = (idx_r == IDX_LAST) ? {IW{1'b0}} : idx_r + IW'(1);
    end else begin
      idx_nxt_s = idx_r;
    end
    // A load landing exactly on the boundary bypasses the shadow so it shows this frame.
    if (frame_s) begin
      pending_nxt_s = 1'b0;
      if (load_i) begin
        shadow_nxt_s = bcd_i;
        disp_nxt_s   = bcd_i;
      end else if (pending_r) begin
        disp_nxt_s = shadow_r;
      end else begin
        disp_nxt_s = disp_r;
      end
    end else if (load_i) begin
      shadow_nxt_s  = bcd_i;
      pending_nxt_s = 1'b1;
    end else begin
      pending_nxt_s = pending_r;
    end
  end

  // Leading-zero blanking, digit select and anode/segment gating
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lzb_s    = {DIGITS{1'b0}};
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (disp_nxt_s[k] == 4'd0);
      lzb_s[k] = (BLANK_LEADING != 0) && (k != 0) && zero_run;
    end
    digit_s  = disp_nxt_s[idx_nxt_s];
    active_s = (tick_nxt_s >= TICK_DEAD) && !blank_i && !lzb_s[idx_nxt_s];
    an_nxt_s = {DIGITS{1'b0}};
    if (active_s) begin
      an_nxt_s[idx_nxt_s] = 1'b1;
      seg_nxt_s           = glyph_s;
      dp_nxt_s            = dp_i[idx_nxt_s];
    end else begin
      seg_nxt_s = SEG_BLANK;
      dp_nxt_s  = 1'b0;
    end
  end

  bcd_2_seg7 u_dec (
    .digit (digit_s),
    .seg   (glyph_s)
  );

  // State and pin registers; outputs track the state they are registered with
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tick_r    <= {TW{1'b0}};
      idx_r     <= {IW{1'b0}};
      shadow_r  <= '0;
      disp_r    <= '0;
      pending_r <= 1'b0;
      seg_o     <= SEG_OFF;
      dp_o      <= DP_OFF;
      an_o      <= AN_OFF;
    end else begin
      tick_r    <= tick_nxt_s;
      idx_r     <= idx_nxt_s;
      shadow_r  <= shadow_nxt_s;
      disp_r    <= disp_nxt_s;
      pending_r <= pending_nxt_s;
      seg_o     <= seg_nxt_s ^ SEG_OFF;
      dp_o      <= dp_nxt_s ^ DP_OFF;
      an_o      <= an_nxt_s ^ AN_OFF;
    end
  end

endmodule
